// File: rtl/retro16_pkg.sv
// Shared Retro16 definitions: sequencer states, writeback source codes and
// the architectural register indices used by the sequencer, regfile and core top.
package retro16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM      = 3'd4,
    ST_WB       = 3'd5,
    ST_INT_LINK = 3'd6,
    ST_INT_VEC  = 3'd7
  } seq_state_e;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_VEC  = 2'd3;

  localparam logic [2:0]  PC_REG_DEF     = 3'd6;
  localparam logic [2:0]  LINK_REG_DEF   = 3'd7;
  localparam logic [15:0] INT_VECTOR_DEF = 16'h0010;

  // Instruction-boundary decision: halt beats irq, and irq is masked inside an ISR.
  function automatic seq_state_e boundary_next(input logic halt, input logic irq,
                                               input logic in_isr);
    if (halt)             return ST_IDLE;
    else if (irq && !in_isr) return ST_INT_LINK;
    else                  return ST_FETCH;
  endfunction

endpackage

// File: rtl/cpu_sequencer_perf_counter.sv
// Retired-instruction counter; wraps silently at 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n)  count <= '0;
    else if (inc)  count <= count + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Retro16 multi-cycle control FSM: fetch/decode/execute/memory/writeback plus
// interrupt entry, RAM handshake and retired-instruction counting.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | parked; all strobes low; boundary check each cycle
// FETCH     | RAM read at PC until mem_ready, latch IR
// DECODE    | settle cycle for the combinational decoder
// EXEC      | ALU result valid, latch condition bits
// MEM       | load/store at ALU address until mem_ready
// WB        | register writeback, PC increment, retire, boundary check
// INT_LINK  | save next-instruction PC into LINK_REG, ack interrupt
// INT_VEC   | load INT_VECTOR into the PC
module cpu_sequencer
  import retro16_pkg::*;
#(
  parameter logic [2:0] PC_REG   = PC_REG_DEF,
  parameter logic [2:0] LINK_REG = LINK_REG_DEF,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             halt,
  input  logic             irq,
  input  logic             iret,
  input  logic             dec_ram_read,
  input  logic             dec_ram_write,
  input  logic [2:0]       dec_dest_reg,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             cond_load,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       wb_reg_ovr,
  output logic             pc_inc,
  output logic             int_ack,
  output logic             in_isr,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_e state, state_next;
  logic       retire;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      in_isr <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_INT_LINK)          in_isr <= 1'b1;
      else if (state == ST_WB && iret)   in_isr <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    cond_load  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    wb_reg_ovr = 3'd0;
    pc_inc     = 1'b0;
    int_ack    = 1'b0;
    retire     = 1'b0;
    case (state)
      ST_IDLE: state_next = boundary_next(halt, irq, in_isr);
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        cond_load  = 1'b1;
        state_next = (dec_ram_read || dec_ram_write) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = dec_ram_write;
        if (mem_ready) state_next = ST_WB;
      end
      ST_WB: begin
        // Branches target R6 directly, so the sequential increment is skipped.
        reg_write  = !dec_ram_write && (dec_dest_reg != 3'd0);
        wb_sel     = dec_ram_read ? WB_MEM : WB_ALU;
        pc_inc     = (dec_dest_reg != PC_REG);
        retire     = 1'b1;
        state_next = boundary_next(halt, irq, in_isr);
      end
      ST_INT_LINK: begin
        reg_write  = 1'b1;
        wb_sel     = WB_LINK;
        wb_reg_ovr = LINK_REG;
        int_ack    = 1'b1;
        state_next = ST_INT_VEC;
      end
      ST_INT_VEC: begin
        reg_write  = 1'b1;
        wb_sel     = WB_VEC;
        wb_reg_ovr = PC_REG;
        state_next = ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  perf_counter #(.CNT_W(CNT_W)) u_perf_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (retire),
    .count   (instr_count)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle strobes and checks every cycle.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, halt, irq, iret, rd, wr, ready;
  logic [2:0]  dest;
  logic        mem_req, mem_we, addr_sel, ir_load, cond_load, reg_write, pc_inc, int_ack, in_isr;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_reg_ovr;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .irq(irq), .iret(iret),
    .dec_ram_read(rd), .dec_ram_write(wr), .dec_dest_reg(dest), .mem_ready(ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .cond_load(cond_load), .reg_write(reg_write), .wb_sel(wb_sel), .wb_reg_ovr(wb_reg_ovr),
    .pc_inc(pc_inc), .int_ack(int_ack), .in_isr(in_isr), .instr_count(instr_count)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  int          last_len;
  int          req_cycles;
  logic [31:0] m_count;
  logic        m_isr;

  wire [13:0] act = {mem_req, mem_we, addr_sel, ir_load, cond_load, reg_write,
                     wb_sel, wb_reg_ovr, pc_inc, int_ack, in_isr};

  function automatic logic [13:0] ev(bit req, bit we, bit asel, bit irl, bit cnd, bit rw,
                                     logic [1:0] wbs, logic [2:0] ovr, bit pci, bit ack);
    return {req, we, asel, irl, cnd, rw, wbs, ovr, pci, ack, m_isr};
  endfunction

  // One clock cycle: inputs already applied just after the previous edge.
  task automatic step(input string nm, input logic [13:0] exp, input bit chk);
    #1;
    if (chk) begin
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s strobes {req,we,asel,irl,cond,rw,wbsel,ovr,pcinc,ack,isr}: got %b expected %b",
                 nm, act, exp);
      end
      checks++;
      if (instr_count !== m_count) begin
        errors++;
        $display("FAIL %s instr_count: got %0d expected %0d", nm, instr_count, m_count);
      end
    end
    if (mem_req) req_cycles++;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic t_idle(input int n);
    for (int i = 0; i < n; i++) step("idle", ev(0,0,0,0,0,0,2'd0,3'd0,0,0), 1);
  endtask

  task automatic t_int();
    step("int_link", ev(0,0,0,0,0,1,2'd2,3'd7,0,1), 1);
    m_isr = 1'b1;
    step("int_vec", ev(0,0,0,0,0,1,2'd3,3'd6,0,0), 1);
  endtask

  task automatic t_fetch(input int fw);
    for (int i = 0; i <= fw; i++) begin
      ready = (i == fw);
      step("fetch", ev(1,0,0,ready,0,0,2'd0,3'd0,0,0), 1);
    end
    ready = 1'b0;
  endtask

  // kind: 0 = ALU/branch, 1 = load, 2 = store
  task automatic instr(input int kind, input logic [2:0] d, input int fw, input int mw,
                       input bit ret, input bit irq_in_exec, input bit halt_in_mem);
    int c0;
    c0 = cyc_n;
    req_cycles = 0;
    t_fetch(fw);
    rd = (kind == 1); wr = (kind == 2); dest = d; iret = ret;
    step("decode", ev(0,0,0,0,0,0,2'd0,3'd0,0,0), 1);
    if (irq_in_exec) irq = 1'b1;
    step("exec", ev(0,0,0,0,1,0,2'd0,3'd0,0,0), 1);
    if (rd || wr) begin
      if (halt_in_mem) halt = 1'b1;
      for (int i = 0; i <= mw; i++) begin
        ready = (i == mw);
        step("mem", ev(1,wr,1,0,0,0,2'd0,3'd0,0,0), 1);
      end
      ready = 1'b0;
    end
    step("wb", ev(0,0,0,0,0, !wr && (d != 3'd0), rd ? 2'd1 : 2'd0, 3'd0, d != 3'd6, 0), 1);
    m_count++;
    if (ret) m_isr = 1'b0;
    iret = 1'b0; rd = 1'b0; wr = 1'b0;
    last_len = cyc_n - c0;
  endtask

  // Boundary rule after WB: halt parks, an unmasked irq enters the ISR, else fetch.
  task automatic follow();
    if (halt)                t_idle(1);
    else if (irq && !m_isr)  t_int();
  endtask

  initial begin
    reset_n = 1'b0; halt = 1'b0; irq = 1'b0; iret = 1'b0;
    rd = 1'b0; wr = 1'b0; dest = 3'd0; ready = 1'b0;
    m_count = '0; m_isr = 1'b0;
    @(posedge clk); #1;

    // reset held three cycles; first cycle state is still unknown
    step("reset0", '0, 0);
    step("reset1", ev(0,0,0,0,0,0,2'd0,3'd0,0,0), 1);
    step("reset2", ev(0,0,0,0,0,0,2'd0,3'd0,0,0), 1);
    reset_n = 1'b1;
    step("release_idle", ev(0,0,0,0,0,0,2'd0,3'd0,0,0), 1);
    lit("count_after_reset", instr_count, 32'd0);

    instr(0, 3'd2, 0, 0, 0, 0, 0);  follow();
    lit("alu_len", last_len, 4);
    lit("alu_count", instr_count, 32'd1);

    instr(1, 3'd3, 0, 3, 0, 0, 0);  follow();
    lit("load_len", last_len, 8);
    lit("load_req_cycles", req_cycles, 5);

    instr(0, 3'd6, 0, 0, 0, 0, 0);  follow();
    instr(2, 3'd0, 0, 0, 0, 0, 0);  follow();
    lit("store_len", last_len, 5);
    instr(2, 3'd5, 0, 1, 0, 0, 0);  follow();
    instr(0, 3'd1, 2, 0, 0, 0, 0);  follow();
    lit("fetch_wait_len", last_len, 6);
    lit("count_6", instr_count, 32'd6);

    // interrupt raised mid-instruction, then ignored inside the ISR
    instr(0, 3'd4, 0, 0, 0, 1, 0);  follow();
    lit("isr_entered", in_isr, 32'd1);
    instr(0, 3'd2, 0, 0, 0, 0, 0);  follow();
    irq = 1'b0;
    instr(0, 3'd3, 0, 0, 1, 0, 0);  follow();
    lit("isr_cleared", in_isr, 32'd0);
    instr(1, 3'd1, 1, 0, 0, 1, 0);  follow();
    irq = 1'b0;
    instr(0, 3'd6, 0, 0, 1, 0, 0);  follow();

    // halt mid-MEM, then halt+irq together, then halt released
    instr(1, 3'd2, 0, 1, 0, 0, 1);  follow();
    t_idle(2);
    irq = 1'b1;
    t_idle(2);
    halt = 1'b0;
    t_idle(1);
    t_int();
    irq = 1'b0;
    instr(0, 3'd5, 0, 0, 0, 0, 0);  follow();
    instr(0, 3'd3, 0, 0, 1, 0, 0);  follow();
    lit("count_14", instr_count, 32'd14);

    // reset during a stalled MEM access
    t_fetch(0);
    rd = 1'b1; dest = 3'd3;
    step("decode", ev(0,0,0,0,0,0,2'd0,3'd0,0,0), 1);
    step("exec", ev(0,0,0,0,1,0,2'd0,3'd0,0,0), 1);
    reset_n = 1'b0;
    step("mem_abort", ev(1,0,1,0,0,0,2'd0,3'd0,0,0), 1);
    m_count = '0; m_isr = 1'b0; rd = 1'b0;
    reset_n = 1'b1;
    step("abort_idle", ev(0,0,0,0,0,0,2'd0,3'd0,0,0), 1);
    instr(0, 3'd2, 0, 0, 0, 0, 0);  follow();
    lit("count_after_abort", instr_count, 32'd1);
    t_idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
